// File: rtl/sram_arb_pkg.sv
// Shared encodings for the unified SRAM bus arbiter: FSM states, owner ids, size codes.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// Build option ARB_RR_EN: round-robin on collisions instead of data-over-inst priority.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant_owner
);

  assign grant_valid = inst_req | data_req;

`ifdef ARB_RR_EN
  always_comb begin
    grant_owner = INST;
    if (inst_req && data_req) begin
      // On a collision the side that did not win last time goes first.
      grant_owner = (last_grant == DATA) ? INST : DATA;
    end else if (data_req) begin
      grant_owner = DATA;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  assign grant_owner = data_req ? DATA : INST;
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data load/store, one transaction in flight.
// Build option ARB_RR_EN: round-robin collision handling with a last_grant register.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q;
  owner_e              owner_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   wdata_q;

  owner_e              last_grant;
  logic                grant_valid;
  owner_e              grant_owner;
  logic                accept;
  logic                finish;

  sram_arb_pick u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

`ifdef ARB_RR_EN
  owner_e last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= INST;
    end else if (accept) begin
      last_grant_q <= grant_owner;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = INST;
`endif

  // Handshakes are gated by reset so an aborted transaction never reports completion.
  assign accept = !reset && (state_q == IDLE) && grant_valid;
  assign finish = !reset && (state_q == WAIT) && bus_data_ok;

  assign inst_addr_ok = accept && (grant_owner == INST);
  assign data_addr_ok = accept && (grant_owner == DATA);
  assign inst_data_ok = finish && (owner_q == INST);
  assign data_data_ok = finish && (owner_q == DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  // Bus request comes straight from state, so the slave handshakes never feed back into it.
  assign bus_req   = (state_q == REQ);
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= INST;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_owner;
            state_q <= REQ;
            if (grant_owner == DATA) begin
              wr_q    <= data_wr;
              size_q  <= data_size;
              addr_q  <= data_addr;
              wstrb_q <= data_wstrb;
              wdata_q <= data_wdata;
            end else begin
              wr_q    <= 1'b0;
              size_q  <= SIZE_WORD;
              addr_q  <= inst_addr;
              wstrb_q <= '0;
              wdata_q <= '0;
            end
          end
        end
        REQ: begin
          if (bus_addr_ok) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus_data_ok) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: queued requesters, a latency-configurable slave, per-cycle monitor.
module tb_sram_bus_arbiter;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  typedef struct {
    logic        owner;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, busy;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return a ^ 32'h0E34_5638;
  endfunction

  dreq_t       data_q[$];
  logic [31:0] inst_q[$];
  exp_t        sb[$];

  int   addr_lat = 0;
  int   data_lat = 1;
  int   cyc = 0;
  int   acc_cyc, breq_cyc, dok_cyc, breq_cnt;
  bit   acc_d, acc_i, dok_seen, in_txn;
  dreq_t cur;

  bit          s_pend;
  int          s_wait, s_dcnt;
  logic [31:0] s_rd;

  // Per cycle: slave + requester drive at posedge+2, monitor at negedge.
  initial begin
    acc_d = 0; acc_i = 0; dok_seen = 0; in_txn = 0;
    s_pend = 0; s_wait = 0; s_dcnt = 0; s_rd = '0;
    acc_cyc = 0; breq_cyc = 0; dok_cyc = 0; breq_cnt = 0;
    cur = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 32'hA5A5_A5A5;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = '0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      bus_addr_ok = 0;
      bus_data_ok = 0;
      bus_rdata   = 32'hA5A5_A5A5;
      if (reset) begin
        data_q.delete(); inst_q.delete(); sb.delete();
        in_txn = 0; s_pend = 0; s_wait = 0;
      end else begin
        if (acc_d && data_q.size() != 0) void'(data_q.pop_front());
        if (acc_i && inst_q.size() != 0) void'(inst_q.pop_front());
        if (acc_d || acc_i) begin in_txn = 1; breq_cnt = 0; end
        if (dok_seen) in_txn = 0;
        if (s_pend) begin
          if (s_dcnt == 0) begin
            bus_data_ok = 1; bus_rdata = s_rd; s_pend = 0;
          end else s_dcnt--;
        end else if (bus_req) begin
          if (s_wait >= addr_lat) begin
            bus_addr_ok = 1; s_pend = 1; s_dcnt = data_lat - 1; s_wait = 0;
            s_rd = bus_wr ? 32'h5555_0000 : slave_rd(bus_addr);
          end else s_wait++;
        end
      end
      acc_d = 0; acc_i = 0; dok_seen = 0;
      data_req = data_q.size() != 0;
      if (data_req) {data_wr, data_size, data_wstrb, data_addr, data_wdata} = data_q[0];
      inst_req = inst_q.size() != 0;
      if (inst_req) inst_addr = inst_q[0];

      @(negedge clk);
      if (!reset) begin
        if (inst_addr_ok || data_addr_ok) begin
          chk("one_grant", inst_addr_ok & data_addr_ok, 0);
          acc_cyc = cyc;
          if (data_addr_ok) begin
            acc_d = 1;
            chk("grant_has_data_req", data_q.size() != 0, 1);
            if (data_q.size() != 0) cur = data_q[0];
          end else begin
            acc_i = 1;
            chk("grant_has_inst_req", inst_q.size() != 0, 1);
            cur = '0;
            cur.size = 2'd2;
            if (inst_q.size() != 0) cur.addr = inst_q[0];
          end
        end
        if (bus_req) begin
          if (breq_cnt == 0) breq_cyc = cyc;
          breq_cnt++;
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_wr_size_wstrb", {bus_wr, bus_size, bus_wstrb}, {cur.wr, cur.size, cur.wstrb});
          chk("bus_wdata", bus_wdata, cur.wdata);
        end
        if (in_txn) chk("busy_in_txn", busy, 1);
        if (inst_data_ok || data_data_ok) begin
          chk("one_dok", inst_data_ok & data_data_ok, 0);
          dok_seen = 1;
          dok_cyc = cyc;
          if (sb.size() == 0) chk("unexpected_dok", sb.size(), 1);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("dok_owner", data_data_ok, e.owner);
            if (e.chk_rd) chk("rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
          end
        end
        if (bus_data_ok) chk("slave_proto_dok_in_wait", busy & ~bus_req, 1);
      end
    end
  end

  task automatic push_data(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
    dreq_t r;
    exp_t  e;
    r.wr = wr; r.size = sz; r.wstrb = st; r.addr = a; r.wdata = wd;
    data_q.push_back(r);
    e.owner = 1'b1; e.chk_rd = !wr; e.rdata = exp_rd;
    sb.push_back(e);
  endtask

  task automatic push_inst(input logic [31:0] a);
    exp_t e;
    inst_q.push_back(a);
    e.owner = 1'b0; e.chk_rd = 1'b1; e.rdata = slave_rd(a);
    sb.push_back(e);
  endtask

  task automatic exp_only(input logic own, input logic [31:0] a);
    exp_t e;
    e.owner = own; e.chk_rd = 1'b1; e.rdata = slave_rd(a);
    sb.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      done = (sb.size() == 0) && (data_q.size() == 0) && (inst_q.size() == 0) && !in_txn;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    @(posedge clk); #1;
    reset = 0;

    // Single load, zero-wait slave
    @(posedge clk); #1;
    addr_lat = 0; data_lat = 1;
    push_data(0, 2'd2, 4'hF, 32'h1C00_0040, 32'h0, 32'h1234_5678);
    drain("drain_load", 40);
    chk("load_busreq_latency", breq_cyc - acc_cyc, 1);
    chk("load_dok_latency", dok_cyc - acc_cyc, 2);

    // Byte store
    @(posedge clk); #1;
    push_data(1, 2'd0, 4'b0010, 32'h0000_0100, 32'h0000_AB00, 32'h0);
    drain("drain_store", 40);
    chk("store_dok_latency", dok_cyc - acc_cyc, 2);

    // Collision from reset release
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    begin
      dreq_t r;
      r = '0; r.size = 2'd2; r.wstrb = 4'hF;
      r.addr = 32'h1000; data_q.push_back(r);
      r.addr = 32'h1004; data_q.push_back(r);
      inst_q.push_back(32'h2000);
      inst_q.push_back(32'h2004);
`ifdef ARB_RR_EN
      exp_only(1, 32'h1000); exp_only(0, 32'h2000);
      exp_only(1, 32'h1004); exp_only(0, 32'h2004);
`else
      exp_only(1, 32'h1000); exp_only(1, 32'h1004);
      exp_only(0, 32'h2000); exp_only(0, 32'h2004);
`endif
    end
    drain("drain_collision", 80);

    // Slave backpressure
    @(posedge clk); #1;
    addr_lat = 5; data_lat = 3;
    push_data(0, 2'd1, 4'b0011, 32'h0000_0346, 32'h0, slave_rd(32'h0000_0346));
    drain("drain_backpressure", 60);
    chk("bp_breq_len", breq_cnt, 6);
    chk("bp_dok_latency", dok_cyc - acc_cyc, 9);

    // Reset while waiting for data
    @(posedge clk); #1;
    addr_lat = 0; data_lat = 6;
    push_data(0, 2'd2, 4'hF, 32'h0000_0800, 32'h0, slave_rd(32'h0000_0800));
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = busy && !bus_req;
    end
    chk("reached_wait", seen, 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_bus_req", bus_req, 0);
    repeat (10) @(posedge clk);
    #1;
    addr_lat = 0; data_lat = 1;
    push_inst(32'h0000_0C00);
    drain("drain_after_reset", 40);
    chk("fetch_dok_latency", dok_cyc - acc_cyc, 2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
